// File: rtl/prng_arbiter.sv
// Round-robin arbiter sharing one Mersenne Twister stream between PORTS requesters,
// plus reseed sequencing that flushes any word prefetched under the old seed.
module prng_arbiter #(
    parameter int PORTS = 4,
    parameter int IDX_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       prng_tdata,
    input  logic              prng_tvalid,
    output logic              prng_tready,
    input  logic              prng_busy,
    output logic [31:0]       prng_seed_val,
    output logic              prng_seed_start,
    input  logic [PORTS-1:0]  rnd_req,
    output logic [PORTS-1:0]  rnd_ack,
    output logic [31:0]       rnd_data,
    input  logic [31:0]       seed_val,
    input  logic              seed_req,
    output logic              seed_ack,
    output logic              busy
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SEED_ISSUE,
        SEED_WAIT,
        SEED_FLUSH
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] last_grant;
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] cand;
    logic             found;

    // First requester after last_grant, wrapping; the last winner is searched last.
    always_comb begin
        pick  = last_grant;
        cand  = '0;
        found = 1'b0;
        for (int i = 1; i <= PORTS; i++) begin
            cand = IDX_W'((int'(last_grant) + i) % PORTS);
            if (!found && rnd_req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            grant_idx       <= '0;
            last_grant      <= IDX_W'(PORTS - 1);
            prng_tready     <= 1'b0;
            prng_seed_start <= 1'b0;
            prng_seed_val   <= '0;
            rnd_ack         <= '0;
            rnd_data        <= '0;
            seed_ack        <= 1'b0;
            busy            <= 1'b0;
        end else begin
            rnd_ack         <= '0;
            seed_ack        <= 1'b0;
            prng_seed_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (seed_req) begin
                        // A pending reseed blocks new grants until the PRNG is free.
                        if (!prng_busy) begin
                            prng_seed_val   <= seed_val;
                            prng_seed_start <= 1'b1;
                            busy            <= 1'b1;
                            state           <= SEED_ISSUE;
                        end
                    end else if (found) begin
                        grant_idx   <= pick;
                        prng_tready <= 1'b1;
                        busy        <= 1'b1;
                        state       <= FETCH;
                    end
                end
                FETCH: begin
                    if (prng_tvalid) begin
                        rnd_data           <= prng_tdata;
                        rnd_ack[grant_idx] <= 1'b1;
                        last_grant         <= grant_idx;
                        prng_tready        <= 1'b0;
                        busy               <= 1'b0;
                        state              <= IDLE;
                    end
                end
                SEED_ISSUE: begin
                    state <= SEED_WAIT;
                end
                SEED_WAIT: begin
                    if (!prng_busy) begin
                        // A word still valid here was generated under the old seed.
                        if (prng_tvalid) begin
                            prng_tready <= 1'b1;
                            state       <= SEED_FLUSH;
                        end else begin
                            seed_ack <= 1'b1;
                            busy     <= 1'b0;
                            state    <= IDLE;
                        end
                    end
                end
                SEED_FLUSH: begin
                    prng_tready <= 1'b0;
                    seed_ack    <= 1'b1;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    prng_tready <= 1'b0;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule
